// File: rtl/vga_fb_ctrl.sv
// VGA timing generator with frame-buffer fetch and built-in test patterns.
// Counters form stage 0; address and all output-side registers load from them on the same pix_en edge.
module vga_fb_ctrl #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int ADDR_W    = 15,
    parameter int PIX_SHIFT = 2,
    parameter int SYNC_POL  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_en,
    input  logic [1:0]        mode,
    input  logic [7:0]        data,
    output logic [ADDR_W-1:0] address,
    output logic [1:0]        red,
    output logic [2:0]        green,
    output logic [2:0]        blue,
    output logic              hsync,
    output logic              vsync,
    output logic              active,
    output logic              frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int CELLS   = H_ACTIVE >> PIX_SHIFT;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic          SYNC_ON = (SYNC_POL != 0);

    logic [HW-1:0]     hcnt_reg;
    logic [VW-1:0]     vcnt_reg;
    logic [1:0]        mode_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              active_reg, hsync_reg, vsync_reg, fs_reg, fb_sel_reg;
    logic [7:0]        pat_reg;

    logic              at_origin, vis_next, hs_next, vs_next;
    logic [1:0]        mode_next;
    logic [2:0]        bar_next;
    logic [7:0]        pat_next;
    logic [ADDR_W-1:0] addr_next;

    always_comb begin
        at_origin = (hcnt_reg == '0) && (vcnt_reg == '0);
        // The frame's first pixel already uses the mode being latched for it.
        mode_next = at_origin ? mode : mode_reg;
        vis_next  = (hcnt_reg < H_VIS) && (vcnt_reg < V_VIS);
        hs_next   = (hcnt_reg >= HS_BEG) && (hcnt_reg < HS_END);
        vs_next   = (vcnt_reg >= VS_BEG) && (vcnt_reg < VS_END);
        bar_next  = 3'(32'(hcnt_reg) / 32'(BAR_W));
        addr_next = ADDR_W'(32'(vcnt_reg >> PIX_SHIFT) * 32'(CELLS)
                          + 32'(hcnt_reg >> PIX_SHIFT));
        pat_next  = 8'h00;
        case (mode_next)
            2'd1:    pat_next = {{2{bar_next[2]}}, {3{bar_next[1]}}, {3{bar_next[0]}}};
            2'd2:    pat_next = (hcnt_reg[4] ^ vcnt_reg[4]) ? 8'hFF : 8'h00;
            2'd3:    pat_next = 8'hFF;
            default: pat_next = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hcnt_reg   <= '0;
            vcnt_reg   <= '0;
            mode_reg   <= 2'd0;
            addr_reg   <= '0;
            active_reg <= 1'b0;
            hsync_reg  <= ~SYNC_ON;
            vsync_reg  <= ~SYNC_ON;
            fs_reg     <= 1'b0;
            fb_sel_reg <= 1'b0;
            pat_reg    <= 8'h00;
        end else if (pix_en) begin
            if (hcnt_reg == H_LAST) begin
                hcnt_reg <= '0;
                vcnt_reg <= (vcnt_reg == V_LAST) ? '0 : vcnt_reg + 1'b1;
            end else begin
                hcnt_reg <= hcnt_reg + 1'b1;
            end
            mode_reg   <= mode_next;
            addr_reg   <= vis_next ? addr_next : '0;
            active_reg <= vis_next;
            hsync_reg  <= hs_next ? SYNC_ON : ~SYNC_ON;
            vsync_reg  <= vs_next ? SYNC_ON : ~SYNC_ON;
            fs_reg     <= at_origin;
            fb_sel_reg <= (mode_next == 2'd0);
            pat_reg    <= pat_next;
        end
    end

    // Frame-buffer colour comes straight from the read port; blanking forces black.
    logic [7:0] colour;
    for (genvar gi = 0; gi < 8; gi++) begin : g_colour
        assign colour[gi] = active_reg & (fb_sel_reg ? data[gi] : pat_reg[gi]);
    end

    assign {red, green, blue} = colour;
    assign address     = addr_reg;
    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign active      = active_reg;
    assign frame_start = fs_reg;
endmodule

// File: tb/tb_vga_fb_ctrl.sv
// Randomised bench for vga_fb_ctrl on a shrunken raster, checked against a pixel-index model.
module tb_vga_fb_ctrl;
    localparam int HA = 64, HF = 4, HS = 8, HB = 4;
    localparam int VA = 16, VF = 2, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int AW = 15, PS = 2;
    localparam logic SP = 1'b0;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          pix_en = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [7:0]    data;
    logic [AW-1:0] address;
    logic [1:0]    red;
    logic [2:0]    green, blue;
    logic          hsync, vsync, active, frame_start;

    int checks = 0;
    int passed = 0;
    int n = 0;
    logic [1:0] frame_mode = 2'd0;

    vga_fb_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .ADDR_W(AW), .PIX_SHIFT(PS), .SYNC_POL(0)
    ) dut (
        .clk(clk), .reset(reset_n), .pix_en(pix_en), .mode(mode), .data(data),
        .address(address), .red(red), .green(green), .blue(blue),
        .hsync(hsync), .vsync(vsync), .active(active), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Frame-buffer memory stand-in: returns address[7:0] one pix_en cycle late.
    always @(posedge clk) begin
        if (!reset_n)    data <= 8'h00;
        else if (pix_en) data <= address[7:0];
    end

    function automatic logic [AW-1:0] model_addr(int p);
        int h, v;
        h = p % HT;
        v = (p / HT) % VT;
        if (h < HA && v < VA) return AW'((v >> PS) * (HA >> PS) + (h >> PS));
        return '0;
    endfunction

    function automatic logic [26:0] expected();
        int p, h, v, b;
        logic a, hs, vs;
        logic [7:0] col;
        logic [AW-1:0] ad, pa;
        if (n == 0) return {{AW{1'b0}}, 8'h00, ~SP, ~SP, 1'b0, 1'b0};
        p  = n - 1;
        h  = p % HT;
        v  = (p / HT) % VT;
        a  = (h < HA) && (v < VA);
        hs = (h >= HA + HF) && (h < HA + HF + HS);
        vs = (v >= VA + VF) && (v < VA + VF + VS);
        ad = model_addr(p);
        pa = (p > 0) ? model_addr(p - 1) : '0;
        b  = h / (HA / 8);
        case (frame_mode)
            2'd0:    col = pa[7:0];
            2'd1:    col = {{2{b[2]}}, {3{b[1]}}, {3{b[0]}}};
            2'd2:    col = (((h >> 4) ^ (v >> 4)) & 1) != 0 ? 8'hFF : 8'h00;
            default: col = 8'hFF;
        endcase
        if (!a) col = 8'h00;
        return {ad, col, hs ? SP : ~SP, vs ? SP : ~SP, a, (h == 0 && v == 0)};
    endfunction

    function automatic logic [26:0] observed();
        return {address, red, green, blue, hsync, vsync, active, frame_start};
    endfunction

    // Advance one clock and move the model along with the inputs applied at that edge.
    task automatic tick();
        int p;
        @(posedge clk);
        if (!reset_n) begin
            n = 0;
        end else if (pix_en) begin
            n++;
            p = n - 1;
            if ((p % HT) == 0 && ((p / HT) % VT) == 0) frame_mode = mode;
        end
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        pix_en  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (observed() !== expected())
                $display("FAIL reset cyc=%0d got=%h exp=%h", i, observed(), expected());
            else passed++;
        end
        reset_n = 1'b1;
    endtask

    task automatic test_timing();
        pix_en = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if ($urandom_range(0, 199) == 0) mode = 2'($urandom_range(0, 3));
            tick();
            checks++;
            if (observed() !== expected())
                $display("FAIL timing cyc=%0d got=%h exp=%h", i, observed(), expected());
            else passed++;
        end
    endtask

    task automatic test_modes();
        int fs_cnt;
        pix_en = 1'b1;
        for (int m = 0; m < 4; m++) begin
            fs_cnt = 0;
            for (int i = 0; i < FRAME; i++) begin
                if (i == FRAME / 3) mode = 2'(m);
                tick();
                if (frame_start) fs_cnt++;
                checks++;
                if (observed() !== expected())
                    $display("FAIL mode%0d cyc=%0d got=%h exp=%h", m, i, observed(), expected());
                else passed++;
            end
            checks++;
            if (fs_cnt !== 1) $display("FAIL fs_per_frame mode%0d got=%0d exp=1", m, fs_cnt);
            else passed++;
        end
    endtask

    task automatic test_fb_pixel();
        int budget;
        mode = 2'd0;
        pix_en = 1'b1;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        budget = 0;
        while (n != 9 * HT + 5 + 1 && budget < 2 * FRAME) begin
            tick();
            budget++;
            checks++;
            if (observed() !== expected())
                $display("FAIL fb_run cyc=%0d got=%h exp=%h", budget, observed(), expected());
            else passed++;
        end
        checks++;
        if (address !== AW'(33)) $display("FAIL fb_addr_5_9 got=%0d exp=33", address);
        else passed++;
        checks++;
        if ({red, green, blue} !== 8'h21) $display("FAIL fb_colour_5_9 got=%h exp=21", {red, green, blue});
        else passed++;
    endtask

    task automatic test_pix_en_toggle();
        int line_clk, last_fs;
        line_clk = 0;
        last_fs = -1;
        for (int i = 0; i < 2 * FRAME + 4; i++) begin
            pix_en = (i % 2 == 0);
            tick();
            if (frame_start && pix_en) begin
                if (last_fs >= 0) line_clk = i - last_fs;
                last_fs = i;
            end
            checks++;
            if (observed() !== expected())
                $display("FAIL pix_toggle cyc=%0d got=%h exp=%h", i, observed(), expected());
            else passed++;
        end
        checks++;
        if (line_clk !== 2 * FRAME && last_fs >= 0 && line_clk != 0)
            $display("FAIL toggle_frame_len got=%0d exp=%0d", line_clk, 2 * FRAME);
        else passed++;
    endtask

    task automatic test_pix_en_random();
        for (int i = 0; i < 2 * FRAME; i++) begin
            pix_en = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 299) == 0) mode = 2'($urandom_range(0, 3));
            tick();
            checks++;
            if (observed() !== expected())
                $display("FAIL pix_random cyc=%0d got=%h exp=%h", i, observed(), expected());
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        pix_en = 1'b1;
        for (int i = 0; i < 10 * HT + 17; i++) tick();
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pix_en = (i != 1);
            tick();
            checks++;
            if (observed() !== {{AW{1'b0}}, 8'h00, ~SP, ~SP, 1'b0, 1'b0})
                $display("FAIL reset_mid cyc=%0d got=%h exp=%h", i, observed(), expected());
            else passed++;
        end
        reset_n = 1'b1;
        pix_en = 1'b0;
        tick();
        checks++;
        if (frame_start !== 1'b0) $display("FAIL fs_before_pix got=%b exp=0", frame_start);
        else passed++;
        pix_en = 1'b1;
        tick();
        checks++;
        if (frame_start !== 1'b1 || active !== 1'b1)
            $display("FAIL fs_after_release got=%b%b exp=11", frame_start, active);
        else passed++;
        for (int i = 0; i < HT + 3; i++) begin
            tick();
            checks++;
            if (observed() !== expected())
                $display("FAIL post_release cyc=%0d got=%h exp=%h", i, observed(), expected());
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_modes();
        test_fb_pixel();
        test_pix_en_toggle();
        test_pix_en_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
